// File: rtl/divider_32by16.sv
// divider_32by16 -- sequential restoring divider, 32-bit dividend by 16-bit
// divisor, one quotient bit per clock.
//
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operands presented on dividend/divisor
//   in_ready   block is idle and can accept an operation (registered)
//   dividend   32-bit unsigned numerator
//   divisor    16-bit unsigned denominator
//   out_valid  result is held on quotient/remainder/err (registered)
//   out_ready  consumer accepts the result
//   quotient   16-bit unsigned quotient (registered)
//   remainder  16-bit unsigned remainder (registered)
//   err        divide-by-zero or quotient overflow flag
//
// Build option:
//   DIV_ERR_CHECK_EN  when defined, a zero divisor or an overflowing
//                     dividend (upper half >= divisor) skips the iterations
//                     and returns err=1, quotient=16'hFFFF and
//                     remainder=dividend[15:0]. When undefined, err is tied
//                     to 0 and every operation runs all 16 iterations.
module divider_32by16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] dividend,
  input  logic [15:0] divisor,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] quotient,
  output logic [15:0] remainder,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state;
  state_t      state_next;

  // The partial remainder never exceeds the divisor-1 between iterations, so
  // its top bit is always zero and only the low 16 bits are stored.
  logic [15:0] partial_rem;
  logic [15:0] shift_lo;
  logic [15:0] quo_acc;
  logic [15:0] div_reg;
  logic [3:0]  count;

  logic        accept;
  logic        release_out;
  logic        bad_ops;
  logic [16:0] trial;
  logic        trial_ge;
  logic [15:0] trial_diff;
  logic [15:0] rem_next;

  // Handshake decode, one restoring step of the datapath, and next state.
  // The subtraction is done modulo 2^16 because whenever it is taken the
  // true difference is below the divisor and therefore fits in 16 bits.
  always_comb begin
    accept      = in_valid & in_ready;
    release_out = out_valid & out_ready;
    trial       = {partial_rem, shift_lo[15]};
    trial_ge    = (trial >= {1'b0, div_reg});
    trial_diff  = trial[15:0] - div_reg;
    rem_next    = trial_ge ? trial_diff : trial[15:0];
`ifdef DIV_ERR_CHECK_EN
    bad_ops     = (divisor == 16'd0) || (dividend[31:16] >= divisor);
`else
    bad_ops     = 1'b0;
`endif
    state_next  = state;
    case (state)
      IDLE: if (accept) state_next = bad_ops ? DONE : CALC;
      CALC: if (count == 4'd15) state_next = DONE;
      DONE: if (release_out) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, datapath and registered handshake outputs. The quotient and
  // remainder outputs are the accumulators themselves; they only change in
  // CALC or at accept, so they are stable for the whole of DONE. On the
  // error shortcut the FSM enters DONE on the accept edge but out_valid
  // rises one edge later, which the (state != IDLE) term provides.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      partial_rem <= 16'd0;
      shift_lo    <= 16'd0;
      quo_acc     <= 16'd0;
      div_reg     <= 16'd0;
      count       <= 4'd0;
    end else begin
      state     <= state_next;
      in_ready  <= (state_next == IDLE);
      out_valid <= (state_next == DONE) && (state != IDLE);
      if (accept) begin
        div_reg <= divisor;
        count   <= 4'd0;
        if (bad_ops) begin
          partial_rem <= dividend[15:0];
          shift_lo    <= 16'd0;
          quo_acc     <= 16'hFFFF;
        end else begin
          partial_rem <= dividend[31:16];
          shift_lo    <= dividend[15:0];
          quo_acc     <= 16'd0;
        end
      end else if (state == CALC) begin
        partial_rem <= rem_next;
        shift_lo    <= {shift_lo[14:0], 1'b0};
        quo_acc     <= {quo_acc[14:0], trial_ge};
        count       <= count + 4'd1;
      end
    end
  end

`ifdef DIV_ERR_CHECK_EN
  // The error flag is captured at accept and held until the next accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (accept) begin
      err <= bad_ops;
    end
  end
`else
  assign err = 1'b0;
`endif

  assign quotient  = quo_acc;
  assign remainder = partial_rem;

endmodule

// File: tb/tb_divider_32by16.sv
// tb_divider_32by16 -- scoreboard bench for divider_32by16. Stimulus pushes
// the expected result into a queue; a monitor pops and compares on every
// output handshake.
module tb_divider_32by16;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        e;
    bit          chk_qr;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  divider_32by16 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .err       (err)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Monitor: every accepted result is compared against the oldest entry.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_result actual=q%0h/r%0h expected=none",
                 quotient, remainder);
      end else begin
        e = sb.pop_front();
        if (e.chk_qr) begin
          checkOutput("result_quotient", {16'd0, quotient}, {16'd0, e.q});
          checkOutput("result_remainder", {16'd0, remainder}, {16'd0, e.r});
        end
        checkOutput("result_err", {31'd0, err}, {31'd0, e.e});
      end
    end
  end

  // Issues one operation from a negedge, measures accept-to-out_valid latency
  // and, with out_ready high, checks the return to idle on the release edge.
  task automatic applyStimulus(input logic [31:0] dd, input logic [15:0] dv,
                               input logic [15:0] eq, input logic [15:0] er,
                               input logic ee, input bit chk, input int lat);
    int n;
    bit got;
    n = 0;
    while (in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("[TB] FAIL in_ready_timeout actual=%b expected=1", in_ready);
      return;
    end
    dividend = dd;
    divisor  = dv;
    in_valid = 1'b1;
    sb.push_back('{eq, er, ee, chk});
    @(posedge clk);
    #1 in_valid = 1'b0;
    n   = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (out_valid === 1'b1) got = 1'b1;
    end
    checkOutput("latency", n, lat);
    if (out_ready === 1'b1) begin
      @(posedge clk);
      #1;
      checkOutput("in_ready_after_release", {31'd0, in_ready}, 32'd1);
      checkOutput("out_valid_after_release", {31'd0, out_valid}, 32'd0);
    end
    @(negedge clk);
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    logic [31:0] rdd;
    logic [15:0] rdv;
    logic [15:0] rhi;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    dividend  = 32'd0;
    divisor   = 16'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset_quotient", {16'd0, quotient}, 32'd0);
    checkOutput("reset_remainder", {16'd0, remainder}, 32'd0);
    checkOutput("reset_err", {31'd0, err}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1 checkOutput("in_ready_after_reset", {31'd0, in_ready}, 32'd1);
    @(negedge clk);

    // Directed vectors with hand-computed results.
    applyStimulus(32'd99, 16'd7, 16'd14, 16'd1, 1'b0, 1'b1, 16);
    applyStimulus(32'hFFFE0001, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 16);
    applyStimulus(32'hFFFEFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0, 1'b1, 16);
    applyStimulus(32'd1000, 16'd3, 16'd333, 16'd1, 1'b0, 1'b1, 16);
    applyStimulus(32'd0, 16'd5, 16'd0, 16'd0, 1'b0, 1'b1, 16);
`ifdef DIV_ERR_CHECK_EN
    applyStimulus(32'h12345678, 16'd0, 16'hFFFF, 16'h5678, 1'b1, 1'b1, 1);
    applyStimulus(32'h00010000, 16'd1, 16'hFFFF, 16'h0000, 1'b1, 1'b1, 1);
    applyStimulus(32'h0000FFFF, 16'd1, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 16);
`else
    applyStimulus(32'h12345678, 16'd0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16);
`endif

    // Backpressure: result held for 10 cycles while a second request waits.
    out_ready = 1'b0;
    dividend  = 32'd5000;
    divisor   = 16'd7;
    in_valid  = 1'b1;
    sb.push_back('{16'd714, 16'd2, 1'b0, 1'b1});
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("bp_latency", n, 16);
    dividend = 32'd77777;
    divisor  = 16'd300;
    in_valid = 1'b1;
    sb.push_back('{16'd259, 16'd77, 1'b0, 1'b1});
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("bp_out_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("bp_quotient", {16'd0, quotient}, 32'd714);
      checkOutput("bp_remainder", {16'd0, remainder}, 32'd2);
      checkOutput("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bp_in_ready_release", {31'd0, in_ready}, 32'd1);
    checkOutput("bp_out_valid_release", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    checkOutput("bp_second_accepted", {31'd0, in_ready}, 32'd0);
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("bp_second_latency", n, 16);
    @(posedge clk);
    @(negedge clk);

    // Reset in the middle of an operation discards it.
    dividend = 32'd40000;
    divisor  = 16'd200;
    in_valid = 1'b1;
    sb.push_back('{16'd200, 16'd0, 1'b0, 1'b1});
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("midrst_quotient", {16'd0, quotient}, 32'd0);
    checkOutput("midrst_remainder", {16'd0, remainder}, 32'd0);
    checkOutput("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 checkOutput("midrst_in_ready_after", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    applyStimulus(32'd1000, 16'd10, 16'd100, 16'd0, 1'b0, 1'b1, 16);

    // Random non-overflowing operands checked against the bench's own divide.
    for (int i = 0; i < 1000; i++) begin
      rdv = 16'($urandom_range(1, 65535));
      rhi = 16'($urandom_range(0, int'(rdv) - 1));
      rdd = {rhi, 16'($urandom)};
      applyStimulus(rdd, rdv, 16'(rdd / {16'd0, rdv}), 16'(rdd % {16'd0, rdv}),
                    1'b0, 1'b1, 16);
    end

    repeat (5) @(negedge clk);
    checkOutput("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
